// File: rtl/pc_seq_pkg.sv
// Shared encodings for the PC sequencer: FSM states, trap cause codes,
// latched redirect kinds and default trap parameters.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_EXEC   = 3'd2,
        S_UPDATE = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_EXT      = 2'd1,
        CAUSE_MISALIGN = 2'd2,
        CAUSE_TIMEOUT  = 2'd3
    } cause_t;

    typedef enum logic [1:0] {
        RD_SEQ    = 2'd0,
        RD_TARGET = 2'd1,
        RD_TRAP   = 2'd2
    } redir_t;

    localparam logic [31:0] EXC_VEC_DEFAULT      = 32'h0000_0180;
    localparam int unsigned IMEM_TIMEOUT_DEFAULT = 15;

    function automatic logic is_misaligned(input logic [1:0] addr_lo);
        return addr_lo != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// Counts FETCH cycles without an instruction-memory ack; expired flags the
// cycle in which the TIMEOUT-th unacknowledged cycle is being spent.
module fetch_watchdog #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= 8'd0;
        end else if (clr) begin
            cnt_q <= 8'd0;
        end else if (en && cnt_q != 8'hFF) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign expired = (cnt_q == LAST_CNT);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute controller: decides each instruction whether the PC steps by 4,
// loads a latched branch/jump target, or traps to the exception vector.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] EXC_VEC      = EXC_VEC_DEFAULT,
    parameter int unsigned IMEM_TIMEOUT = IMEM_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] pc_cur,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        ir_ld,
    input  logic        exec_done,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp_valid,
    input  logic [31:0] jmp_target,
    input  logic        exc_req,
    output logic        exc_ack,
    input  logic        halt_req,
    input  logic        stall,
    output logic        pc_ld,
    output logic        pc_inc,
    output logic [31:0] pc_next,
    output logic [31:0] epc,
    output logic [1:0]  exc_cause,
    output logic        halted
);

    state_t      state_q, state_d;
    redir_t      redir_q, redir_d;
    cause_t      cause_q, cause_d;
    logic [31:0] target_q, target_d;
    logic        halt_q, halt_d;
    logic [31:0] epc_q;
    cause_t      exc_cause_q;

    logic wd_expired;
    logic fetch_timeout;
    logic update_go;

    fetch_watchdog #(.TIMEOUT(IMEM_TIMEOUT)) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clr     (state_q != S_FETCH),
        .en      (state_q == S_FETCH && !imem_ack),
        .expired (wd_expired)
    );

    // An ack in the expiring cycle takes precedence over the watchdog.
    assign fetch_timeout = (state_q == S_FETCH) && !imem_ack && wd_expired;
    assign update_go     = (state_q == S_UPDATE) && !stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_FETCH;
            S_FETCH: begin
                if (imem_ack)        state_d = S_EXEC;
                else if (wd_expired) state_d = S_UPDATE;
            end
            S_EXEC:   if (exec_done) state_d = S_UPDATE;
            S_UPDATE: if (!stall) state_d = halt_q ? S_HALT : S_FETCH;
            S_HALT:   if (start) state_d = S_FETCH;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        redir_d  = redir_q;
        cause_d  = cause_q;
        target_d = target_q;
        halt_d   = halt_q;
        if (fetch_timeout) begin
            redir_d = RD_TRAP;
            cause_d = CAUSE_TIMEOUT;
            halt_d  = 1'b0;
        end else if (state_q == S_EXEC && exec_done) begin
            halt_d   = halt_req;
            cause_d  = CAUSE_NONE;
            target_d = 32'd0;
            if (exc_req) begin
                redir_d = RD_TRAP;
                cause_d = CAUSE_EXT;
            end else if (jmp_valid) begin
                target_d = jmp_target;
                redir_d  = is_misaligned(jmp_target[1:0]) ? RD_TRAP : RD_TARGET;
                cause_d  = is_misaligned(jmp_target[1:0]) ? CAUSE_MISALIGN : CAUSE_NONE;
            end else if (br_taken) begin
                target_d = br_target;
                redir_d  = is_misaligned(br_target[1:0]) ? RD_TRAP : RD_TARGET;
                cause_d  = is_misaligned(br_target[1:0]) ? CAUSE_MISALIGN : CAUSE_NONE;
            end else begin
                redir_d = RD_SEQ;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            redir_q     <= RD_SEQ;
            cause_q     <= CAUSE_NONE;
            target_q    <= 32'd0;
            halt_q      <= 1'b0;
            epc_q       <= 32'd0;
            exc_cause_q <= CAUSE_NONE;
        end else begin
            redir_q  <= redir_d;
            cause_q  <= cause_d;
            target_q <= target_d;
            halt_q   <= halt_d;
            if (update_go && redir_q == RD_TRAP) begin
                epc_q       <= pc_cur;
                exc_cause_q <= cause_q;
            end
        end
    end

    // Redirect controls come only from latched registers, never from redirect inputs.
    always_comb begin
        imem_req = 1'b0;
        ir_ld    = 1'b0;
        exc_ack  = 1'b0;
        pc_ld    = 1'b0;
        pc_inc   = 1'b0;
        pc_next  = 32'd0;
        halted   = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_ld    = imem_ack;
            end
            S_UPDATE: begin
                if (!stall) begin
                    case (redir_q)
                        RD_TRAP: begin
                            pc_ld   = 1'b1;
                            pc_next = EXC_VEC;
                            exc_ack = 1'b1;
                        end
                        RD_TARGET: begin
                            pc_ld   = 1'b1;
                            pc_next = target_q;
                        end
                        default: pc_inc = 1'b1;
                    endcase
                end
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    assign epc       = epc_q;
    assign exc_cause = exc_cause_q;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Multi-cycle fetch/execute controller that drives the program counter's load/increment controls and next-PC value. It sits between the instruction memory handshake, the execute datapath and the program counter register. Each cycle it decides whether the PC holds, steps by 4 or loads a redirect target. Redirect sources are branch, jump, exception vector, and a fetch watchdog that traps stalled instruction-memory accesses.

## Interface
- EXC_VEC, 32'h0000_0180, exception/trap target loaded into the PC
- IMEM_TIMEOUT, 15, FETCH cycles without `imem_ack` before a bus-error trap (1..255)
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- start  in  1  leave IDLE/HALT and begin fetching
- pc_cur  in  32  current PC register value
- imem_req  out  1  instruction fetch request, held until ack
- imem_ack  in  1  instruction word valid this cycle
- ir_ld  out  1  load instruction register (1-cycle pulse)
- exec_done  in  1  datapath finished current instruction
- br_taken  in  1  branch taken; sampled with exec_done
- br_target  in  32  branch target
- jmp_valid  in  1  jump; sampled with exec_done
- jmp_target  in  32  jump target
- exc_req  in  1  external exception, level, held until exc_ack
- exc_ack  out  1  1-cycle pulse when any trap is taken
- halt_req  in  1  stop after current instruction; sampled with exec_done
- stall  in  1  freeze PC update in UPDATE
- pc_ld  out  1  load PC with pc_next
- pc_inc  out  1  PC += 4
- pc_next  out  32  redirect target; valid when pc_ld=1, else 0
- epc  out  32  PC of trapped instruction
- exc_cause  out  2  0 none, 1 external, 2 misaligned target, 3 fetch timeout
- halted  out  1  high in HALT

## Operation
- States: IDLE, FETCH, EXEC, UPDATE, HALT.
- Reset values: state IDLE; every output 0, including epc and exc_cause; watchdog count 0; latched redirect regs cleared.
- IDLE: when start=1, go to FETCH.
- FETCH: imem_req=1.
  - On imem_ack: ir_ld=1 that cycle, then EXEC.
  - Watchdog counts FETCH cycles without ack. When the count reaches IMEM_TIMEOUT with no ack, latch the trap with cause 3, then UPDATE. An ack in the same cycle wins.
- EXEC: wait for exec_done. In the exec_done cycle, latch one redirect using this priority:
  - exc_req, cause 1
  - jmp_valid, target jmp_target
  - br_taken, target br_target
  - sequential
  - A latched jump or branch target with bits [1:0]≠0 becomes a trap with cause 2.
  - halt_req is latched in the same cycle.
  - Then go to UPDATE.
- UPDATE:
  - If stall=1: hold; all control outputs 0.
  - Else, for one cycle, exactly one of these:
    - trap: pc_ld=1, pc_next=EXC_VEC, exc_ack=1, epc←pc_cur, exc_cause←cause
    - jump or branch: pc_ld=1, pc_next=target
    - sequential: pc_inc=1
  - Next state is HALT if halt was latched, else FETCH.
- HALT: halted=1, no requests. start=1 goes to FETCH.
- pc_ld and pc_inc are never both 1. Neither is ever 1 outside UPDATE.
- epc and exc_cause change only on a trap. They persist until the next trap or reset.

## Timing
- Best case 3 cycles/instruction (ack in the first FETCH cycle, exec_done in the first EXEC cycle).
- PC updates on the edge ending UPDATE; the next FETCH sees the new pc_cur.
- Outputs are decoded from registered state and latched regs only. There is no combinational path from redirect inputs to pc_ld/pc_next.
- Redirect inputs are ignored except in the exec_done cycle. exc_req outside that cycle stays pending, because the source holds it.
- Watchdog clears on entry to FETCH.
- Reset mid-FETCH drops imem_req asynchronously. The memory must tolerate an abandoned request.

## Structure
- Shared package pc_seq_pkg: state encoding, exc_cause codes, default EXC_VEC.
- One sub-module: fetch_watchdog, an 8-bit counter with clear/enable/expire (inputs clk, reset, clr, en; output expired).

## Test plan
- Sequential: start, ack after 1 cycle, exec_done immediately, pc_cur=0x100 → pc_inc pulses once on cycle 3, ir_ld on cycle 1, no pc_ld.
- Priority: exec_done with jmp_valid=1 (0x200), br_taken=1 (0x300), exc_req=0 → pc_ld=1, pc_next=0x200. Repeat with exc_req=1 → pc_next=0x180, exc_ack=1, exc_cause=1, epc=pc_cur.
- Misaligned: br_taken=1, br_target=0x202 → pc_next=0x180, exc_cause=2.
- Timeout: imem_ack held 0 → imem_req high exactly 15 cycles, then UPDATE traps with exc_cause=3. Ack arriving on cycle 15 → normal fetch, no trap.
- Stall/halt: stall=1 for 4 cycles in UPDATE → pc_inc delayed 4 cycles. halt_req with exec_done → halted=1 after UPDATE; start → FETCH resumes.
- Reset: drive reset=0 mid-EXEC → all outputs 0 immediately, state IDLE, epc=0.
